// File: rtl/wfg_stim_pkg.sv
// Shared types, constants and the Q8.8 scaling helper
// for the waveform-generator stimulus memory reader.
package wfg_stim_pkg;

    localparam int STIM_DATA_W    = 32;
    localparam int STIM_GAIN_W    = 16;
    localparam int GAIN_FRAC_BITS = 8;
    localparam int PROD_W         = STIM_DATA_W + STIM_GAIN_W + 1;

    localparam logic [STIM_DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [STIM_DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic {
        IDLE,
        RUN
    } stim_state_e;

    // Signed sample times unsigned gain, >>> frac bits, clamped to DATA_W.
    function automatic logic [STIM_DATA_W-1:0] sat_scale(
        input logic [STIM_DATA_W-1:0] sample,
        input logic [STIM_GAIN_W-1:0] gain
    );
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shr;
        prod = $signed({{(PROD_W-STIM_DATA_W){sample[STIM_DATA_W-1]}}, sample})
             * $signed({{(PROD_W-STIM_GAIN_W){1'b0}}, gain});
        shr  = prod >>> GAIN_FRAC_BITS;
        if ((&shr[PROD_W-1:STIM_DATA_W-1]) || !(|shr[PROD_W-1:STIM_DATA_W-1]))
            sat_scale = shr[STIM_DATA_W-1:0];
        else if (shr[PROD_W-1])
            sat_scale = SAT_MIN;
        else
            sat_scale = SAT_MAX;
    endfunction

endpackage

// File: rtl/wfg_stim_mem_if.sv
// Valid/ready sample stream from the stimulus reader
// to the SPI and pattern drivers.
interface wfg_stim_mem_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/wfg_stim_fifo.sv
// Two-entry synchronous FIFO with flush, feeding the
// stimulus stream; head entry drives the output directly.
module wfg_stim_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              pop;

    assign rd_valid_o = (count_q != 2'd0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign pop        = rd_valid_o & rd_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, wr_en_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/wfg_stim_mem.sv
// Streams gain-scaled samples from the SRAM read port,
// walking a start/end/stride address window while enabled.
module wfg_stim_mem
    import wfg_stim_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = STIM_DATA_W,
    parameter int GAIN_W = STIM_GAIN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_en_i,
    input  logic [ADDR_W-1:0] cfg_start_i,
    input  logic [ADDR_W-1:0] cfg_end_i,
    input  logic [7:0]        cfg_inc_i,
    input  logic [GAIN_W-1:0] cfg_gain_i,
    output logic              csb1_o,
    output logic [ADDR_W-1:0] addr1_o,
    input  logic [DATA_W-1:0] dout1_i,
    wfg_stim_mem_if.master    stim,
    output logic              active_o
);

    stim_state_e       state_q, state_d;
    logic              csb1_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] end_q;
    logic [7:0]        inc_q;
    logic              cap_q;

    logic              run, enter, leave, pop, issue, wrap;
    logic [2:0]        occ;
    logic [1:0]        fifo_cnt;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic [DATA_W-1:0] scaled;
    logic [7:0]        inc_fix;
    logic [ADDR_W:0]   nxt;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ctrl_en_i)  state_d = RUN;
            RUN:  if (!ctrl_en_i) state_d = IDLE;
        endcase
    end

    assign run   = (state_q == RUN) & ctrl_en_i;
    assign enter = (state_q == IDLE) & ctrl_en_i;
    assign leave = (state_q == RUN) & ~ctrl_en_i;
    assign pop   = fifo_valid & stim.tready;

    // Requested + captured + buffered must still fit after this pop.
    assign occ   = {1'b0, fifo_cnt} + {2'b0, ~csb1_q} + {2'b0, cap_q};
    assign issue = run & (occ <= ({2'b0, pop} + 3'd1));

    assign inc_fix = (cfg_inc_i == 8'd0) ? 8'd1 : cfg_inc_i;
    assign nxt     = {1'b0, ptr_q} + {{(ADDR_W-7){1'b0}}, inc_q};
    assign wrap    = nxt[ADDR_W] | (nxt[ADDR_W-1:0] > end_q);
    assign scaled  = sat_scale(dout1_i, cfg_gain_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            csb1_q  <= 1'b1;
            addr1_q <= '0;
            ptr_q   <= '0;
            end_q   <= '0;
            inc_q   <= 8'd1;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            csb1_q  <= ~issue;
            cap_q   <= run & ~csb1_q;
            if (enter) begin
                ptr_q <= cfg_start_i;
                end_q <= cfg_end_i;
                inc_q <= inc_fix;
            end else if (issue) begin
                addr1_q <= ptr_q;
                if (wrap) begin
                    ptr_q <= cfg_start_i;
                    end_q <= cfg_end_i;
                    inc_q <= inc_fix;
                end else begin
                    ptr_q <= nxt[ADDR_W-1:0];
                end
            end
        end
    end

    wfg_stim_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (leave),
        .wr_en_i    (cap_q & run),
        .wr_data_i  (scaled),
        .rd_ready_i (stim.tready),
        .rd_valid_o (fifo_valid),
        .rd_data_o  (fifo_data),
        .count_o    (fifo_cnt)
    );

    assign csb1_o      = csb1_q;
    assign addr1_o     = addr1_q;
    assign stim.tvalid = fifo_valid;
    assign stim.tdata  = fifo_data;
    assign active_o    = (state_q == RUN);

endmodule
